mult_div_sequencer: RTL

- Multi-cycle MIPS multiply/divide unit that sits beside the single-cycle execution ALU in the EX stage.
- Sequences MULT/MULTU/DIV/DIVU over 32 shift-add or restoring-divide iterations.
- Owns the HI/LO registers and services MTHI/MTLO and MFHI/MFLO.
- Raises a stall to the pipeline when an instruction needs HI/LO or the unit while an operation is in flight.

---
 rtl/mdu_pkg.sv | 26 ++
 rtl/mdu_iter_step.sv | 41 ++++
 rtl/mult_div_sequencer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings and sizing constants for the multiply/divide unit.
package mdu_pkg;

  localparam int MDU_XLEN        = 32;
  localparam int MDU_ITER_CYCLES = 32;
  localparam int MDU_CNT_W       = $clog2(MDU_ITER_CYCLES + 1);
  // start sampled in cycle 0, done pulse in this cycle
  localparam int MDU_LATENCY     = MDU_ITER_CYCLES + 3;

  // bit 1 selects divide, bit 0 selects unsigned
  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PREP  = 3'd1,
    ST_ITER  = 3'd2,
    ST_FIXUP = 3'd3,
    ST_DONE  = 3'd4
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter_step.sv
// One shift-add multiply or restoring-divide iteration, purely combinational.
// hi/lo form the 2*XLEN working register: accumulator:multiplier for
// multiply, remainder:quotient for divide.
module mdu_iter_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] opb_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0]   add_sum;
  logic [XLEN:0]   add_sel;
  logic [XLEN:0]   rem_shift;
  logic            trial_ge;
  logic [XLEN-1:0] rem_sub;

  // Select multiply add/shift or divide trial-subtract for this iteration
  always_comb begin
    // 33-bit add keeps the carry that is shifted back into the accumulator
    add_sum   = {1'b0, hi_i} + {1'b0, opb_i};
    add_sel   = lo_i[0] ? add_sum : {1'b0, hi_i};
    // remainder shifted left by one, pulling in the next dividend bit
    rem_shift = {hi_i, lo_i[XLEN-1]};
    // 33-bit trial: the shifted remainder can exceed XLEN bits
    trial_ge  = (rem_shift >= {1'b0, opb_i});
    // when the trial succeeds the difference is below the divisor, so it fits
    rem_sub   = rem_shift[XLEN-1:0] - opb_i;
    if (is_div) begin
      hi_o = trial_ge ? rem_sub : rem_shift[XLEN-1:0];
      lo_o = {lo_i[XLEN-2:0], trial_ge};
    end else begin
      hi_o = add_sel[XLEN:1];
      lo_o = {add_sel[0], lo_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_sequencer.sv
// Multi-cycle MIPS MULT/MULTU/DIV/DIVU unit owning HI/LO, with pipeline stall.
module mult_div_sequencer
  import mdu_pkg::*;
#(
  parameter int XLEN        = MDU_XLEN,
  parameter int ITER_CYCLES = MDU_ITER_CYCLES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  input  logic            mthi,
  input  logic            mtlo,
  input  logic [XLEN-1:0] wdata,
  input  logic            mfhi,
  input  logic            mflo,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            done,
  output logic            stall
);

  localparam int CNT_W = $clog2(ITER_CYCLES + 1);

  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // datapath state: no reset needed, always loaded before use
  logic [1:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;         // original dividend, kept for divide-by-zero
  logic [XLEN-1:0]   opb_q, opb_d;     // raw b until PREP, then multiplicand/divisor
  logic [XLEN-1:0]   acc_hi_q, acc_hi_d;
  logic [XLEN-1:0]   acc_lo_q, acc_lo_d;
  logic              neg_a_q, neg_a_d;
  logic              neg_b_q, neg_b_d;

  logic              accept;
  logic              is_signed;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   step_hi;
  logic [XLEN-1:0]   step_lo;

  mdu_iter_step #(.XLEN(XLEN)) u_step (
    .is_div (op_q[1]),
    .hi_i   (acc_hi_q),
    .lo_i   (acc_lo_q),
    .opb_i  (opb_q),
    .hi_o   (step_hi),
    .lo_o   (step_lo)
  );

  // Next-state, datapath and HI/LO update for the whole sequence
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    op_d      = op_q;
    a_d       = a_q;
    opb_d     = opb_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    neg_a_d   = neg_a_q;
    neg_b_d   = neg_b_q;
    accept    = start && (state_q == ST_IDLE || state_q == ST_DONE);
    is_signed = ~op_q[0];
    mag_a     = a_q;
    mag_b     = opb_q;
    prod      = {acc_hi_q, acc_lo_q};
    quo       = acc_lo_q;
    rem       = acc_hi_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          // a new operation beats any MTHI/MTLO on the same edge
          state_d = ST_PREP;
          op_d    = op;
          a_d     = a_in;
          opb_d   = b_in;
        end else begin
          state_d = ST_IDLE;
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      ST_PREP: begin
        neg_a_d  = is_signed & a_q[XLEN-1];
        neg_b_d  = is_signed & opb_q[XLEN-1];
        // two's-complement negate; the most negative value maps to itself
        // and is then read as an unsigned magnitude
        mag_a    = neg_a_d ? (~a_q + 1'b1) : a_q;
        mag_b    = neg_b_d ? (~opb_q + 1'b1) : opb_q;
        acc_hi_d = '0;
        if (op_q[1]) begin
          acc_lo_d = mag_a;
          opb_d    = mag_b;
        end else begin
          acc_lo_d = mag_b;
          opb_d    = mag_a;
        end
        cnt_d   = '0;
        state_d = ST_ITER;
      end
      ST_ITER: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ITER_CYCLES - 1)) state_d = ST_FIXUP;
      end
      ST_FIXUP: begin
        if (!op_q[1]) begin
          if (is_signed && (neg_a_q ^ neg_b_q)) prod = ~prod + 1'b1;
          hi_d = prod[2*XLEN-1:XLEN];
          lo_d = prod[XLEN-1:0];
        end else if (opb_q == '0) begin
          // divide by zero: fixed result, no sign correction
          hi_d = a_q;
          lo_d = '1;
        end else begin
          if (is_signed && (neg_a_q ^ neg_b_q)) quo = ~quo + 1'b1;
          if (is_signed && neg_a_q)             rem = ~rem + 1'b1;
          hi_d = rem;
          lo_d = quo;
        end
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_PREP) || (state_d == ST_ITER) || (state_d == ST_FIXUP);
    done_d = (state_d == ST_DONE);
  end

  // Control state and architectural HI/LO, cleared by reset from any state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Working operands and accumulator for the in-flight operation
  always_ff @(posedge clk) begin
    op_q     <= op_d;
    a_q      <= a_d;
    opb_q    <= opb_d;
    acc_hi_q <= acc_hi_d;
    acc_lo_q <= acc_lo_d;
    neg_a_q  <= neg_a_d;
    neg_b_q  <= neg_b_d;
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign stall = busy_q & (start | mfhi | mflo | mthi | mtlo);

endmodule
